// File: rtl/pool_layer.sv
// 2x2 stride-2 max pooling with ReLU over a multi-channel feature map held in DRAM.
// Reads four words per window (one-cycle read latency), writes one pooled word.
module pool_layer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18,
   parameter int IN_WIDTH   = 28,
   parameter int IN_HEIGHT  = 28,
   parameter int NUM_CHNL   = 6,
   parameter int IN_BASE    = 4096,
   parameter int OUT_BASE   = 24576
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  dram_en_rd,
   output logic                  dram_en_wr,
   output logic                  done
);

   typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_LAST, ST_WR, ST_DONE} state_t;

   localparam logic [3:0] OX_LAST = 4'(IN_WIDTH / 2 - 1);
   localparam logic [3:0] OY_LAST = 4'(IN_HEIGHT / 2 - 1);
   localparam logic [3:0] CH_LAST = 4'(NUM_CHNL - 1);
   localparam logic [ADDR_WIDTH-1:0] IN_BASE_A  = ADDR_WIDTH'(IN_BASE);
   localparam logic [ADDR_WIDTH-1:0] OUT_BASE_A = ADDR_WIDTH'(OUT_BASE);

   state_t                state_reg, state_next;
   logic [1:0]            k_reg, k_next;
   logic [3:0]            ox_reg, ox_next;
   logic [3:0]            oy_reg, oy_next;
   logic [3:0]            chnl_reg, chnl_next;
   logic [DATA_WIDTH-1:0] max_reg, max_next;

   logic                  greater;
   logic                  last_window;
   logic [13:0]           rd_offset;
   logic [13:0]           wr_offset;
   logic [DATA_WIDTH-1:0] relu_val;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= ST_IDLE;
         k_reg     <= '0;
         ox_reg    <= '0;
         oy_reg    <= '0;
         chnl_reg  <= '0;
         max_reg   <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         ox_reg    <= ox_next;
         oy_reg    <= oy_next;
         chnl_reg  <= chnl_next;
         max_reg   <= max_next;
      end
   end

   assign greater     = $signed(data_in) > $signed(max_reg);
   assign last_window = (oy_reg == OY_LAST) && (ox_reg == OX_LAST) && (chnl_reg == CH_LAST);

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      ox_next    = ox_reg;
      oy_next    = oy_reg;
      chnl_next  = chnl_reg;
      max_next   = max_reg;
      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next = ST_RD;
               k_next     = '0;
               ox_next    = '0;
               oy_next    = '0;
               chnl_next  = '0;
            end
         end
         ST_RD: begin
            // data_in lags the address by one cycle: k=1 sees the k=0 word
            k_next = k_reg + 2'd1;
            if (k_reg == 2'd3) state_next = ST_LAST;
            if (k_reg == 2'd1) max_next = data_in;
            else if (k_reg != 2'd0 && greater) max_next = data_in;
         end
         ST_LAST: begin
            if (greater) max_next = data_in;
            state_next = ST_WR;
         end
         ST_WR: begin
            state_next = last_window ? ST_DONE : ST_RD;
            if (oy_reg == OY_LAST) begin
               oy_next = '0;
               if (ox_reg == OX_LAST) begin
                  ox_next   = '0;
                  chnl_next = chnl_reg + 4'd1;
               end else begin
                  ox_next = ox_reg + 4'd1;
               end
            end else begin
               oy_next = oy_reg + 4'd1;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // {chnl, x, y} with x = 2*ox+dx and y = 2*oy+dy, five bits each for x and y
   assign rd_offset = {chnl_reg, ox_reg, k_reg[0], oy_reg, k_reg[1]};
   assign wr_offset = {chnl_reg, 1'b0, ox_reg, 1'b0, oy_reg};

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_relu
         assign relu_val[gi] = max_reg[gi] & ~max_reg[DATA_WIDTH-1];
      end
   endgenerate

   always_comb begin
      dram_en_rd = (state_reg == ST_RD);
      dram_en_wr = (state_reg == ST_WR);
      done       = (state_reg == ST_DONE);
      addr_in    = dram_en_rd ? IN_BASE_A + ADDR_WIDTH'(rd_offset) : '0;
      addr_out   = dram_en_wr ? OUT_BASE_A + ADDR_WIDTH'(wr_offset) : '0;
      data_out   = dram_en_wr ? relu_val : '0;
   end

endmodule

// File: tb/tb_pool_layer.sv
// Scoreboarded bench for pool_layer: a DRAM model feeds random maps, a reference
// pooling model predicts every write, and a monitor compares writes as they appear.
module tb_pool_layer;

   localparam int DW = 32;
   localparam int AW = 18;
   localparam int IW = 28;
   localparam int IH = 28;
   localparam int NC = 6;
   localparam int IB = 4096;
   localparam int OB = 24576;

   logic          clk = 1'b0;
   logic          srst = 1'b1;
   logic          enable = 1'b0;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic [AW-1:0] addr_in;
   logic [AW-1:0] addr_out;
   logic          dram_en_rd;
   logic          dram_en_wr;
   logic          done;

   pool_layer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .IN_HEIGHT(IH),
      .NUM_CHNL(NC), .IN_BASE(IB), .OUT_BASE(OB)
   ) dut (
      .clk(clk), .srst(srst), .enable(enable), .data_in(data_in),
      .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
      .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
   } exp_t;

   logic [31:0] mem [0:(1<<AW)-1];
   exp_t        exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int wr_count, done_count, first_rd_cyc, first_wr_cyc, done_cyc;
   bit rd_seen;
   int unsigned last_wr_addr;
   logic [31:0] wr_data_first [0:2];

   // DRAM model with one-cycle read latency; garbage when not reading
   always @(posedge clk) begin
      if (dram_en_rd) data_in <= mem[addr_in];
      else            data_in <= $urandom();
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Monitor: scoreboard pop on each write, plus run statistics
   always @(negedge clk) begin
      cyc++;
      if (dram_en_rd && !rd_seen) begin
         rd_seen      = 1'b1;
         first_rd_cyc = cyc;
      end
      if (dram_en_wr) begin
         if (wr_count == 0) first_wr_cyc = cyc;
         if (wr_count < 3) wr_data_first[wr_count] = data_out;
         wr_count++;
         last_wr_addr = addr_out;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {46'd0, addr_out}, 64'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("WR #%0d addr=%0d data=%08h exp_addr=%0d exp_data=%08h",
                     wr_count, addr_out, data_out, e.addr, e.data);
            check("wr_addr", {46'd0, addr_out}, {32'd0, e.addr});
            check("wr_data", {32'd0, data_out}, {32'd0, e.data});
         end
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      wr_count   = 0;
      done_count = 0;
      rd_seen    = 1'b0;
      first_rd_cyc = 0;
      first_wr_cyc = 0;
      done_cyc     = 0;
      last_wr_addr = 0;
   endtask

   function automatic int unsigned in_addr(input int c, input int x, input int y);
      return IB + c * 1024 + x * 32 + y;
   endfunction

   task automatic fill_random();
      for (int c = 0; c < NC; c++)
         for (int x = 0; x < IW; x++)
            for (int y = 0; y < IH; y++)
               mem[in_addr(c, x, y)] = $urandom();
   endtask

   task automatic set_window(input int oy, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      mem[in_addr(0, 0, 2*oy)]     = w0;
      mem[in_addr(0, 1, 2*oy)]     = w1;
      mem[in_addr(0, 0, 2*oy + 1)] = w2;
      mem[in_addr(0, 1, 2*oy + 1)] = w3;
   endtask

   // Reference: max of each 2x2 block as signed integers, clamped at zero
   task automatic build_expected();
      for (int c = 0; c < NC; c++)
         for (int ox = 0; ox < IW/2; ox++)
            for (int oy = 0; oy < IH/2; oy++) begin
               exp_t e;
               longint m = -(64'sd1 <<< 40);
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++) begin
                     longint v = longint'($signed(mem[in_addr(c, 2*ox+dx, 2*oy+dy)]));
                     if (v > m) m = v;
                  end
               e.addr = OB + c * 1024 + ox * 32 + oy;
               e.data = (m < 0) ? 32'd0 : 32'(m);
               exp_q.push_back(e);
            end
   endtask

   task automatic start_and_check_reads(input string tag);
      int n;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      n = 0;
      while (!dram_en_rd && n < 20) begin tick(); n++; end
      check({tag, "_rd_started"}, {63'd0, dram_en_rd}, 64'd1);
      check({tag, "_rd0"}, {46'd0, addr_in}, 64'd4096); tick();
      check({tag, "_rd1"}, {46'd0, addr_in}, 64'd4128); tick();
      check({tag, "_rd2"}, {46'd0, addr_in}, 64'd4097); tick();
      check({tag, "_rd3"}, {46'd0, addr_in}, 64'd4129);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_count < target && n < 10000) begin tick(); n++; end
      check("done_seen", {32'd0, done_count}, {32'd0, target});
   endtask

   task automatic full_run(input string tag);
      clear_stats();
      build_expected();
      start_and_check_reads(tag);
      wait_done(1);
      check({tag, "_first_wr_lat"}, {32'd0, first_wr_cyc - first_rd_cyc}, 64'd5);
      check({tag, "_done_lat"}, {32'd0, done_cyc - first_rd_cyc}, 64'd7056);
      check({tag, "_wr_count"}, {32'd0, wr_count}, 64'd1176);
      check({tag, "_last_wr_addr"}, {32'd0, last_wr_addr}, 64'd30125);
      check({tag, "_queue_empty"}, {32'd0, exp_q.size()}, 64'd0);
      for (int i = 0; i < 4; i++) tick();
      check({tag, "_single_done"}, {32'd0, done_count}, 64'd1);
      check({tag, "_idle_no_rd"}, {63'd0, dram_en_rd}, 64'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data_out"}, {32'd0, data_out}, 64'd0);
      check({tag, "_addr_in"}, {46'd0, addr_in}, 64'd0);
      check({tag, "_addr_out"}, {46'd0, addr_out}, 64'd0);
      check({tag, "_ctrl"}, {61'd0, dram_en_rd, dram_en_wr, done}, 64'd0);
   endtask

   initial begin
      clear_stats();
      srst = 1'b1;
      tick(); tick();
      check_outputs_zero("reset");
      srst = 1'b0;
      tick();
      check_outputs_zero("idle");

      // Run 1: random map with hand-picked windows at the start of channel 0
      fill_random();
      set_window(0, 32'hFFFB_0000, 32'h0003_0000, 32'h0007_0000, 32'hFFFF_0000);
      set_window(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
      set_window(2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0001);
      full_run("run1");
      check("win_fixed_point", {32'd0, wr_data_first[0]}, 64'h0007_0000);
      check("win_all_negative", {32'd0, wr_data_first[1]}, 64'd0);
      check("win_signed_cmp", {32'd0, wr_data_first[2]}, 64'h7FFF_FFFF);

      // Run 2: reset during ST_LAST of window 10, then restart from scratch
      fill_random();
      clear_stats();
      build_expected();
      start_and_check_reads("abort");
      for (int i = 0; i < 61; i++) tick();
      check("abort_wr_before_reset", {32'd0, wr_count}, 64'd10);
      srst = 1'b1;
      tick();
      check_outputs_zero("abort_reset");
      srst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_access", {62'd0, dram_en_rd, dram_en_wr}, 64'd0);
      end
      exp_q.delete();
      full_run("restart");

      // Run 3: enable held high across a whole run
      fill_random();
      clear_stats();
      build_expected();
      build_expected();
      enable = 1'b1;
      tick();
      begin
         int n = 0;
         while (!dram_en_rd && n < 20) begin tick(); n++; end
      end
      check("hold_rd_started", {46'd0, addr_in}, 64'd4096);
      wait_done(1);
      check("hold_wr_count", {32'd0, wr_count}, 64'd1176);
      check("hold_done_lat", {32'd0, done_cyc - first_rd_cyc}, 64'd7056);
      tick();
      check("hold_idle_gap", {63'd0, dram_en_rd}, 64'd0);
      tick();
      check("hold_restart_rd", {63'd0, dram_en_rd}, 64'd1);
      check("hold_restart_addr", {46'd0, addr_in}, 64'd4096);
      enable = 1'b0;
      wait_done(2);
      check("hold_total_writes", {32'd0, wr_count}, 64'd2352);
      check("hold_queue_empty", {32'd0, exp_q.size()}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
